// File: rtl/dbus_pkg.sv
// Shared constants and response-register payload for the data-bus arbiter.
package dbus_pkg;

  // Slave select encoding
  localparam logic SEL_RAM  = 1'b0;
  localparam logic SEL_GPIO = 1'b1;

  // Master id encoding
  localparam logic MST_CORE = 1'b0;
  localparam logic MST_DBG  = 1'b1;

  // First GPIO byte address; everything below maps to RAM
  localparam int unsigned ADDR_END1_DEF = 4096;

  // Outstanding-read tracking across the one-cycle slave latency
  typedef struct packed {
    logic pend;
    logic mst;
    logic sel;
  } rsp_t;

endpackage

// File: rtl/dbus_prio_arb.sv
// Fixed-priority two-way grant with a starvation counter that bounds how long m1 waits.
module dbus_prio_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_gnt,
  output logic m1_gnt
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_cnt_d;
  logic          m1_win;

  // Grant decision; m1 overrides m0 once it has been denied STARVE_MAX cycles in a row
  always_comb begin
    m1_win = m1_req & (~m0_req | (starve_cnt == CW'(STARVE_MAX)));
    m1_gnt = rst_n & m1_win;
    m0_gnt = rst_n & m0_req & ~m1_win;
  end

  // Starvation counter next value: clear on m1 idle or win, else saturating count
  always_comb begin
    starve_cnt_d = starve_cnt;
    if (!m1_req || m1_win) begin
      starve_cnt_d = '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt + CW'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: grant, address decode to RAM/GPIO and read-data return routing.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned ADDR_END1  = ADDR_END1_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req_i,
  input  logic          m1_req_i,
  input  logic          m0_we_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m0_gnt_o,
  output logic          m1_gnt_o,
  output logic          m0_rvalid_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          ram_req_o,
  output logic          gpio_req_o,
  output logic          ram_we_o,
  output logic          gpio_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [AW-1:0] gpio_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  output logic [DW-1:0] gpio_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  input  logic [DW-1:0] gpio_rdata_i
);

  logic          xfer;
  logic          sel;
  logic          we_w;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] wdata_w;
  logic [DW-1:0] rd_data;
  rsp_t          rsp_q;
  rsp_t          rsp_d;

  dbus_prio_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .m0_req (m0_req_i),
    .m1_req (m1_req_i),
    .m0_gnt (m0_gnt_o),
    .m1_gnt (m1_gnt_o)
  );

  // Winner mux and slave decode; grants are already gated by reset
  always_comb begin
    xfer    = m0_gnt_o | m1_gnt_o;
    we_w    = m1_gnt_o ? m1_we_i    : m0_we_i;
    addr_w  = m1_gnt_o ? m1_addr_i  : m0_addr_i;
    wdata_w = m1_gnt_o ? m1_wdata_i : m0_wdata_i;
    sel     = (addr_w >= AW'(ADDR_END1)) ? SEL_GPIO : SEL_RAM;
  end

  // Slave-side strobes and forwarded payload
  always_comb begin
    ram_req_o    = xfer & (sel == SEL_RAM);
    gpio_req_o   = xfer & (sel == SEL_GPIO);
    ram_we_o     = ram_req_o & we_w;
    gpio_we_o    = gpio_req_o & we_w;
    ram_addr_o   = addr_w;
    gpio_addr_o  = addr_w;
    ram_wdata_o  = wdata_w;
    gpio_wdata_o = wdata_w;
  end

  // Next response entry: only an accepted read leaves something outstanding
  always_comb begin
    rsp_d      = '0;
    rsp_d.pend = xfer & ~we_w;
    rsp_d.mst  = m1_gnt_o ? MST_DBG : MST_CORE;
    rsp_d.sel  = sel;
  end

  // Response register; async clear drops any in-flight read immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Route returning read data only to the master that issued the read
  always_comb begin
    rd_data     = (rsp_q.sel == SEL_GPIO) ? gpio_rdata_i : ram_rdata_i;
    m0_rvalid_o = rsp_q.pend & (rsp_q.mst == MST_CORE);
    m1_rvalid_o = rsp_q.pend & (rsp_q.mst == MST_DBG);
    m0_rdata_o  = m0_rvalid_o ? rd_data : '0;
    m1_rdata_o  = m1_rvalid_o ? rd_data : '0;
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: driver queues expectations, negedge monitor checks them.
module tb_dbus_arbiter;

  localparam logic [31:0] RAM_D  = 32'hDEAD_BEEF;
  localparam logic [31:0] GPIO_D = 32'h600D_F00D;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk;
  logic        rst_n;
  logic        m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        ram_req_o, gpio_req_o, ram_we_o, gpio_we_o;
  logic [31:0] ram_addr_o, gpio_addr_o, ram_wdata_o, gpio_wdata_o;
  logic [31:0] ram_rdata_i, gpio_rdata_i;

  typedef struct {
    int          cyc;
    logic        g0, g1, rr, gr, rwe, gwe;
    logic [31:0] addr, wdata;
  } cexp_t;

  typedef struct {
    int          due;
    logic        mst;
    logic [31:0] data;
  } rexp_t;

  cexp_t cq[$];
  rexp_t rq[$];
  cexp_t mc;
  rexp_t mr;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  dbus_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_i     (m0_req_i),
    .m1_req_i     (m1_req_i),
    .m0_we_i      (m0_we_i),
    .m1_we_i      (m1_we_i),
    .m0_addr_i    (m0_addr_i),
    .m1_addr_i    (m1_addr_i),
    .m0_wdata_i   (m0_wdata_i),
    .m1_wdata_i   (m1_wdata_i),
    .m0_gnt_o     (m0_gnt_o),
    .m1_gnt_o     (m1_gnt_o),
    .m0_rvalid_o  (m0_rvalid_o),
    .m1_rvalid_o  (m1_rvalid_o),
    .m0_rdata_o   (m0_rdata_o),
    .m1_rdata_o   (m1_rdata_o),
    .ram_req_o    (ram_req_o),
    .gpio_req_o   (gpio_req_o),
    .ram_we_o     (ram_we_o),
    .gpio_we_o    (gpio_we_o),
    .ram_addr_o   (ram_addr_o),
    .gpio_addr_o  (gpio_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .gpio_wdata_o (gpio_wdata_o),
    .ram_rdata_i  (ram_rdata_i),
    .gpio_rdata_i (gpio_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of requests with hand-computed grant/strobe expectations
  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic eg0, input logic eg1, input logic ers, input logic egs);
    cexp_t c;
    rexp_t r;
    m0_req_i = r0; m0_we_i = w0; m0_addr_i = a0; m0_wdata_i = d0;
    m1_req_i = r1; m1_we_i = w1; m1_addr_i = a1; m1_wdata_i = d1;
    c.cyc   = cyc;
    c.g0    = eg0;
    c.g1    = eg1;
    c.rr    = ers;
    c.gr    = egs;
    c.rwe   = ers & (eg1 ? w1 : w0);
    c.gwe   = egs & (eg1 ? w1 : w0);
    c.addr  = eg1 ? a1 : a0;
    c.wdata = eg1 ? d1 : d0;
    cq.push_back(c);
    if ((eg0 && !w0) || (eg1 && !w1)) begin
      r.due  = cyc + 1;
      r.mst  = eg1;
      r.data = egs ? GPIO_D : RAM_D;
      rq.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L);
  endtask

  task automatic rd0(input logic [31:0] a, input logic ers, input logic egs);
    step(H, L, a, 32'h0, L, L, 32'h0, 32'h0, H, L, ers, egs);
  endtask

  task automatic rd1(input logic [31:0] a, input logic ers, input logic egs);
    step(L, L, 32'h0, 32'h0, H, L, a, 32'h0, L, H, ers, egs);
  endtask

  // Monitor: compare queued expectations against the DUT on the falling edge
  always @(negedge clk) begin : monitor
    logic        ev0, ev1;
    logic [31:0] ed0, ed1;
    while (cq.size() > 0 && cq[0].cyc == cyc) begin
      mc = cq.pop_front();
      chk("m0_gnt", 32'(m0_gnt_o), 32'(mc.g0));
      chk("m1_gnt", 32'(m1_gnt_o), 32'(mc.g1));
      chk("ram_req", 32'(ram_req_o), 32'(mc.rr));
      chk("gpio_req", 32'(gpio_req_o), 32'(mc.gr));
      chk("ram_we", 32'(ram_we_o), 32'(mc.rwe));
      chk("gpio_we", 32'(gpio_we_o), 32'(mc.gwe));
      if (mc.rr) chk("ram_addr", ram_addr_o, mc.addr);
      if (mc.gr) chk("gpio_addr", gpio_addr_o, mc.addr);
      if (mc.rwe) chk("ram_wdata", ram_wdata_o, mc.wdata);
      if (mc.gwe) chk("gpio_wdata", gpio_wdata_o, mc.wdata);
    end
    ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mr = rq.pop_front();
      if (mr.mst) begin
        ev1 = 1'b1; ed1 = mr.data;
      end else begin
        ev0 = 1'b1; ed0 = mr.data;
      end
    end
    chk("m0_rvalid", 32'(m0_rvalid_o), 32'(ev0));
    chk("m1_rvalid", 32'(m1_rvalid_o), 32'(ev1));
    chk("m0_rdata", m0_rdata_o, ed0);
    chk("m1_rdata", m1_rdata_o, ed1);
  end

  initial begin
    rst_n = 1'b0;
    m0_req_i = 1'b0; m1_req_i = 1'b0; m0_we_i = 1'b0; m1_we_i = 1'b0;
    m0_addr_i = 32'h0; m1_addr_i = 32'h0; m0_wdata_i = 32'h0; m1_wdata_i = 32'h0;
    ram_rdata_i = RAM_D;
    gpio_rdata_i = GPIO_D;
    @(posedge clk);
    #1;

    // Reset forces grants and strobes low even with both masters requesting
    step(H, L, 32'h100, 32'h0, H, L, 32'h1000, 32'h0, L, L, L, L);
    step(H, L, 32'h100, 32'h0, H, L, 32'h1000, 32'h0, L, L, L, L);
    rst_n = 1'b1;
    idle();

    // Single RAM read, request dropped the next cycle
    rd0(32'h100, H, L);
    idle();

    // Decode boundaries, back-to-back
    rd0(32'h0000_0FFC, H, L);
    rd0(32'h0000_1000, L, H);
    rd0(32'hFFFF_FFFF, L, H);
    idle();

    // m1 alone
    rd1(32'h10, H, L);
    idle();

    // Contention: m1 wins in cycles 4 and 9 only
    for (int i = 0; i < 10; i++) begin
      logic s;
      s = (i == 4) || (i == 9);
      step(H, L, 32'h200, 32'h0, H, L, 32'h2000, 32'h0, ~s, s, ~s, s);
    end
    idle();

    // Alternating masters and slaves without a bubble
    rd0(32'h40, H, L);
    rd1(32'h1008, L, H);
    idle();

    // m1 GPIO write: no rvalid follows
    step(L, L, 32'h0, 32'h0, H, H, 32'h1004, 32'h55, L, H, L, H);
    idle();

    // Read then write: read data returns during the write's grant cycle
    rd0(32'h80, H, L);
    step(H, H, 32'h84, 32'h1234, L, L, 32'h0, 32'h0, H, L, H, L);
    idle();

    // Reset in the cycle after an accepted read discards the response at once
    rd0(32'h100, H, L);
    chk("pre_rst_rvalid", 32'(m0_rvalid_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", 32'(m0_rvalid_o), 32'h0);
    chk("rst_rdata", m0_rdata_o, 32'h0);
    rq.delete();
    step(H, L, 32'h100, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L);
    step(H, L, 32'h100, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L);
    m0_req_i = 1'b0;
    rst_n = 1'b1;
    idle();
    idle();
    rd0(32'h104, H, L);
    idle();
    idle();

    chk("resp_queue_drained", 32'(rq.size()), 32'h0);
    chk("cycle_queue_drained", 32'(cq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
